lcm_bupdate_tx: RTL and testbench

Beacon-update transmitter: builds a 4-line beacon update packet in the 134-bit pipeline format and drives it into an LCM packet-input port. It runs on the controller side and is the initiator for the update messages that the LCM consumes. It snapshots the requested configuration, a sequence number and a timestamp at packet start. It sends on a software trigger or, optionally, on an internal period.

---
 rtl/lcm_bupdate_tx.sv | 152 +++++++++++++++
 tb/tb_lcm_bupdate_tx.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcm_bupdate_tx.sv
// Beacon-update transmitter: 4-line 134-bit update packet into an LCM port.
// Define BUPDATE_PERIODIC_EN to add a free-running periodic trigger.
module lcm_bupdate_tx #(
  parameter logic [7:0]  LMID   = 8'd1,
  parameter logic [31:0] PERIOD = 32'd125000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send_req,
  input  logic         pktin_ready,
  input  logic [47:0]  precision_time,
  input  logic [47:0]  dst_mac,
  input  logic [47:0]  src_mac,
  input  logic         cfg_direction,
  input  logic [31:0]  cfg_token_bucket_para,
  input  logic [47:0]  cfg_direct_mac_addr,
  input  logic [31:0]  cfg_time_slot_period,
  output logic [133:0] out_data,
  output logic         out_data_wr,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  output logic         tx_busy,
  output logic [31:0]  tx_seq
);

  typedef enum logic [2:0] {
    IDLE, L0, L1, L2, L3, VLD
  } state_t;

  state_t      state;
  logic        pend;
  logic        trig;
  logic        start;

  logic [47:0] sh_dst;
  logic [47:0] sh_src;
  logic [47:0] sh_time;
  logic [47:0] sh_dmac;
  logic        sh_dir;
  logic [31:0] sh_tbp;
  logic [31:0] sh_tsp;
  logic [31:0] sh_seq;

`ifdef BUPDATE_PERIODIC_EN
  logic [31:0] per_cnt;
  logic        per_exp;

  // Free-running; PERIOD of zero leaves the counter parked with no expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      per_exp <= 1'b0;
    end else begin
      per_exp <= 1'b0;
      if (PERIOD != 32'd0) begin
        if (per_cnt >= PERIOD - 32'd1) begin
          per_cnt <= '0;
          per_exp <= 1'b1;
        end else begin
          per_cnt <= per_cnt + 32'd1;
        end
      end
    end
  end

  assign trig = send_req | per_exp;
`else
  if (PERIOD == 32'd0) begin : g_no_period
  end

  assign trig = send_req;
`endif

  assign start = (state == IDLE) & (pend | trig) & pktin_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      pend              <= 1'b0;
      out_data          <= '0;
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      tx_busy           <= 1'b0;
      tx_seq            <= '0;
      sh_dst            <= '0;
      sh_src            <= '0;
      sh_time           <= '0;
      sh_dmac           <= '0;
      sh_dir            <= 1'b0;
      sh_tbp            <= '0;
      sh_tsp            <= '0;
      sh_seq            <= '0;
    end else begin
      out_data_wr       <= 1'b0;
      out_data_valid    <= 1'b0;
      out_data_valid_wr <= 1'b0;
      // Triggers during a packet fold into a single follow-up request.
      pend <= (pend | trig) & ~start;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_dst  <= dst_mac;
            sh_src  <= src_mac;
            sh_time <= precision_time;
            sh_dmac <= cfg_direct_mac_addr;
            sh_dir  <= cfg_direction;
            sh_tbp  <= cfg_token_bucket_para;
            sh_tsp  <= cfg_time_slot_period;
            sh_seq  <= tx_seq;
            tx_busy <= 1'b1;
            state   <= L0;
          end
        end
        L0: begin
          out_data <= {2'b01, 4'h0, sh_dst, sh_src,
                       16'h1662, 8'h02, LMID};
          out_data_wr <= 1'b1;
          state       <= L1;
        end
        L1: begin
          out_data <= {2'b11, 4'h0, 7'd0, sh_dir, sh_tbp,
                       sh_dmac, sh_tsp, 8'h00};
          out_data_wr <= 1'b1;
          state       <= L2;
        end
        L2: begin
          out_data <= {2'b11, 4'h0, sh_seq, sh_time, 48'h0};
          out_data_wr <= 1'b1;
          state       <= L3;
        end
        L3: begin
          out_data    <= {2'b10, 4'h0, 128'h0};
          out_data_wr <= 1'b1;
          state       <= VLD;
        end
        VLD: begin
          out_data_valid    <= 1'b1;
          out_data_valid_wr <= 1'b1;
          tx_seq            <= tx_seq + 32'd1;
          tx_busy           <= 1'b0;
          state             <= IDLE;
        end
        default: begin
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_bupdate_tx.sv
// Randomized bench for lcm_bupdate_tx against a packet-level model.
// Define BUPDATE_PERIODIC_EN to exercise the periodic trigger instead.
module tb_lcm_bupdate_tx;

`ifdef BUPDATE_PERIODIC_EN
  localparam logic [31:0] PER = 32'd100;
`else
  localparam logic [31:0] PER = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         send_req = 1'b0;
  logic         pktin_ready = 1'b0;
  logic [47:0]  precision_time = '0;
  logic [47:0]  dst_mac = '0;
  logic [47:0]  src_mac = '0;
  logic         cfg_direction = 1'b0;
  logic [31:0]  cfg_token_bucket_para = '0;
  logic [47:0]  cfg_direct_mac_addr = '0;
  logic [31:0]  cfg_time_slot_period = '0;
  logic [133:0] out_data;
  logic         out_data_wr;
  logic         out_data_valid;
  logic         out_data_valid_wr;
  logic         tx_busy;
  logic [31:0]  tx_seq;

  lcm_bupdate_tx #(.LMID(8'd1), .PERIOD(PER)) dut (
    .clk(clk), .rst(rst), .send_req(send_req),
    .pktin_ready(pktin_ready), .precision_time(precision_time),
    .dst_mac(dst_mac), .src_mac(src_mac),
    .cfg_direction(cfg_direction),
    .cfg_token_bucket_para(cfg_token_bucket_para),
    .cfg_direct_mac_addr(cfg_direct_mac_addr),
    .cfg_time_slot_period(cfg_time_slot_period),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_data_valid(out_data_valid),
    .out_data_valid_wr(out_data_valid_wr),
    .tx_busy(tx_busy), .tx_seq(tx_seq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dst, src, tm, dmac;
    logic        dir;
    logic [31:0] tbp, tsp;
  } snap_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] model_seq = '0;

  logic [133:0] lq[$];
  int lt[$];
  int vt[$];
  logic vv[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs 2 ns after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst) begin
      if (out_data_wr) begin
        lq.push_back(out_data);
        lt.push_back(cyc);
      end
      if (out_data_valid_wr) begin
        vt.push_back(cyc);
        vv.push_back(out_data_valid);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [133:0] exp_line(int i, snap_t s,
                                            logic [31:0] seq);
    logic [127:0] p;
    logic [1:0]   tag;
    case (i)
      0: p = {s.dst, s.src, 16'h1662, 8'h02, 8'd1};
      1: p = {7'd0, s.dir, s.tbp, s.dmac, s.tsp, 8'h00};
      2: p = {seq, s.tm, 48'd0};
      default: p = '0;
    endcase
    tag = (i == 0) ? 2'b01 : (i == 3) ? 2'b10 : 2'b11;
    return {tag, 4'h0, p};
  endfunction

  function automatic snap_t cur_snap();
    snap_t s;
    s.dst = dst_mac; s.src = src_mac; s.tm = precision_time;
    s.dmac = cfg_direct_mac_addr; s.dir = cfg_direction;
    s.tbp = cfg_token_bucket_para; s.tsp = cfg_time_slot_period;
    return s;
  endfunction

  task automatic rand_cfg();
    dst_mac = {16'($urandom), $urandom};
    src_mac = {16'($urandom), $urandom};
    precision_time = {16'($urandom), $urandom};
    cfg_direct_mac_addr = {16'($urandom), $urandom};
    cfg_direction = 1'($urandom);
    cfg_token_bucket_para = $urandom;
    cfg_time_slot_period = $urandom;
  endtask

  task automatic clear_q();
    lq.delete(); lt.delete(); vt.delete(); vv.delete();
  endtask

  task automatic pulse_send();
    @(negedge clk) send_req = 1'b1;
    @(negedge clk) send_req = 1'b0;
  endtask

  task automatic wait_vld(int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (vt.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_seq = '0;
  endtask

  task automatic test_reset();
    total++;
    if (out_data !== 134'd0 || out_data_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: got %h/%b want 0/0", out_data, out_data_wr);
    end
    total++;
    if (out_data_valid !== 1'b0 || out_data_valid_wr !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b/%b want 0/0",
               out_data_valid, out_data_valid_wr);
    end
    total++;
    if (tx_busy !== 1'b0 || tx_seq !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b seq=%h want 0/0",
               tx_busy, tx_seq);
    end
  endtask

  task automatic test_basic();
    snap_t s;
    int t0;
    bit ok;
    clear_q();
    rand_cfg();
    cfg_time_slot_period = 32'h7A12;
    pktin_ready = 1'b1;
    s = cur_snap();
    pulse_send();
    t0 = cyc;
    total++;
    if (tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: got %b want 1", tx_busy);
    end
    wait_vld(1, ok);
    total++;
    if (!ok || lq.size() != 4) begin
      bad++;
      $display("FAIL basic_count: got lines=%0d want 4", lq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (lq[i] !== exp_line(i, s, model_seq) || lt[i] != t0 + 1 + i) begin
          bad++;
          $display("FAIL basic_line%0d: got %h@%0d want %h@%0d", i, lq[i],
                   lt[i], exp_line(i, s, model_seq), t0 + 1 + i);
        end
      end
      total++;
      if (lq[1][39:8] !== 32'h00007A12) begin
        bad++;
        $display("FAIL basic_tsp: got %h want 00007a12", lq[1][39:8]);
      end
      total++;
      if (vt[0] != t0 + 5 || vv[0] !== 1'b1) begin
        bad++;
        $display("FAIL basic_vld: got %0d/%b want %0d/1", vt[0], vv[0],
                 t0 + 5);
      end
    end
    model_seq++;
    total++;
    if (tx_seq !== model_seq || tx_busy !== 1'b0
        || out_data !== exp_line(3, s, 0)) begin
      bad++;
      $display("FAIL basic_after: got seq=%h busy=%b want %h/0",
               tx_seq, tx_busy, model_seq);
    end
  endtask

  task automatic test_collapse();
    snap_t s;
    bit ok;
    clear_q();
    rand_cfg();
    pktin_ready = 1'b0;
    repeat (3) begin
      pulse_send();
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    total++;
    if (lq.size() != 0 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL collapse_wait: got lines=%0d want 0", lq.size());
    end
    s = cur_snap();
    pktin_ready = 1'b1;
    wait_vld(1, ok);
    repeat (12) @(negedge clk);
    total++;
    if (!ok || vt.size() != 1 || lq.size() != 4) begin
      bad++;
      $display("FAIL collapse_count: got pkts=%0d want 1", vt.size());
    end else begin
      total++;
      if (lq[2] !== exp_line(2, s, model_seq)) begin
        bad++;
        $display("FAIL collapse_seq: got %h want %h", lq[2],
                 exp_line(2, s, model_seq));
      end
    end
    model_seq++;
  endtask

  task automatic test_capture();
    snap_t s;
    bit ok;
    clear_q();
    rand_cfg();
    pktin_ready = 1'b1;
    s = cur_snap();
    pulse_send();
    repeat (4) begin
      rand_cfg();
      @(negedge clk);
    end
    wait_vld(1, ok);
    total++;
    if (!ok || lq.size() != 4) begin
      bad++;
      $display("FAIL capture_count: got lines=%0d want 4", lq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (lq[i] !== exp_line(i, s, model_seq)) begin
          bad++;
          $display("FAIL capture_line%0d: got %h want %h", i, lq[i],
                   exp_line(i, s, model_seq));
        end
      end
    end
    model_seq++;
  endtask

  task automatic test_back_to_back();
    snap_t s;
    int t0;
    bit ok;
    clear_q();
    rand_cfg();
    pktin_ready = 1'b1;
    s = cur_snap();
    pulse_send();
    t0 = cyc;
    pulse_send();
    @(negedge clk);
    pulse_send();
    wait_vld(2, ok);
    repeat (10) @(negedge clk);
    total++;
    if (!ok || vt.size() != 2 || lq.size() != 8) begin
      bad++;
      $display("FAIL b2b_count: got pkts=%0d want 2", vt.size());
    end else begin
      total++;
      if (vt[0] != t0 + 5 || vt[1] != t0 + 11 || lt[4] != t0 + 7) begin
        bad++;
        $display("FAIL b2b_timing: got %0d,%0d want %0d,%0d", vt[0],
                 vt[1], t0 + 5, t0 + 11);
      end
      for (int i = 0; i < 8; i++) begin
        total++;
        if (lq[i] !== exp_line(i % 4, s, model_seq + 32'(i / 4))) begin
          bad++;
          $display("FAIL b2b_line%0d: got %h want %h", i, lq[i],
                   exp_line(i % 4, s, model_seq + 32'(i / 4)));
        end
      end
    end
    model_seq += 2;
  endtask

  task automatic test_random();
    snap_t s;
    int t0;
    bit ok;
    for (int n = 0; n < 6; n++) begin
      clear_q();
      rand_cfg();
      pktin_ready = 1'b0;
      pulse_send();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      s = cur_snap();
      pktin_ready = 1'b1;
      @(negedge clk);
      t0 = cyc;
      repeat (4) begin
        rand_cfg();
        @(negedge clk);
      end
      wait_vld(1, ok);
      total++;
      if (!ok || lq.size() != 4) begin
        bad++;
        $display("FAIL rand%0d_count: got lines=%0d want 4", n, lq.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          total++;
          if (lq[i] !== exp_line(i, s, model_seq) || lt[i] != t0 + 1 + i) begin
            bad++;
            $display("FAIL rand%0d_line%0d: got %h@%0d want %h@%0d", n, i,
                     lq[i], lt[i], exp_line(i, s, model_seq), t0 + 1 + i);
          end
        end
      end
      model_seq++;
      total++;
      if (tx_seq !== model_seq) begin
        bad++;
        $display("FAIL rand%0d_seq: got %h want %h", n, tx_seq, model_seq);
      end
    end
  endtask

  task automatic test_mid_reset();
    snap_t s;
    bit ok;
    clear_q();
    rand_cfg();
    pktin_ready = 1'b1;
    pulse_send();
    pulse_send();
    rst = 1'b1;
    #1;
    total++;
    if (out_data_wr !== 1'b0 || tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: got wr=%b busy=%b want 0/0",
               out_data_wr, tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    model_seq = '0;
    repeat (10) @(negedge clk);
    total++;
    if (vt.size() != 0 || lq.size() != 2 || out_data_wr !== 1'b0) begin
      bad++;
      $display("FAIL midrst_partial: got pkts=%0d lines=%0d want 0/2",
               vt.size(), lq.size());
    end
    total++;
    if (tx_seq !== model_seq) begin
      bad++;
      $display("FAIL midrst_seq: got %h want %h", tx_seq, model_seq);
    end
    clear_q();
    s = cur_snap();
    pulse_send();
    wait_vld(1, ok);
    total++;
    if (!ok || lq.size() != 4) begin
      bad++;
      $display("FAIL midrst_next: got lines=%0d want 4", lq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (lq[i] !== exp_line(i, s, model_seq)) begin
          bad++;
          $display("FAIL midrst_line%0d: got %h want %h", i, lq[i],
                   exp_line(i, s, model_seq));
        end
      end
    end
    model_seq++;
  endtask

  task automatic test_wrap();
    snap_t s;
    bit ok;
    clear_q();
    @(negedge clk);
    force dut.tx_seq = 32'hFFFFFFFF;
    #1;
    release dut.tx_seq;
    model_seq = 32'hFFFFFFFF;
    rand_cfg();
    pktin_ready = 1'b1;
    s = cur_snap();
    pulse_send();
    wait_vld(1, ok);
    total++;
    if (!ok || lq.size() != 4) begin
      bad++;
      $display("FAIL wrap_count: got lines=%0d want 4", lq.size());
    end else begin
      total++;
      if (lq[2] !== exp_line(2, s, model_seq)) begin
        bad++;
        $display("FAIL wrap_line2: got %h want %h", lq[2],
                 exp_line(2, s, model_seq));
      end
    end
    model_seq++;
    total++;
    if (tx_seq !== model_seq) begin
      bad++;
      $display("FAIL wrap_seq: got %h want %h", tx_seq, model_seq);
    end
  endtask

  task automatic test_periodic();
    clear_q();
    pktin_ready = 1'b1;
    repeat (430) @(negedge clk);
    total++;
    if (vt.size() < 3 || lq.size() < 12) begin
      bad++;
      $display("FAIL per_count: got pkts=%0d want >=3", vt.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if (lq[4 * k + 2][127:96] !== model_seq + 32'(k)) begin
          bad++;
          $display("FAIL per_seq%0d: got %h want %h", k,
                   lq[4 * k + 2][127:96], model_seq + 32'(k));
        end
      end
      for (int k = 1; k < 3; k++) begin
        total++;
        if (vt[k] - vt[k - 1] != 100) begin
          bad++;
          $display("FAIL per_gap%0d: got %0d want 100", k,
                   vt[k] - vt[k - 1]);
        end
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
`ifdef BUPDATE_PERIODIC_EN
    test_periodic();
`else
    test_basic();
    test_collapse();
    test_capture();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
